mmio_uart_tx: RTL

Memory-mapped UART transmitter that responds to the pipeline CPU's data-memory bus (address, write data, MemRead, MemWrite) and serialises bytes on a single TX pin. The CPU's MEM stage is the initiator; this block is the responder, decoded in parallel with data memory. Stores to its data register are queued in a small FIFO and shifted out as 8N1 frames. Loads return status and configuration in the same cycle.

---
 rtl/uart_mmio_pkg.sv | 26 ++
 rtl/uart_tx_fifo.sv | 61 ++++++
 rtl/mmio_uart_tx.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared register map, STATUS bit positions and TX FSM encoding for the MMIO UART transmitter.
// Constants only; no timing or flow-control behaviour of its own.
package uart_mmio_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_BAUDDIV = 4'h8;

  // Word index within the 16-byte window (addr[3:2]).
  localparam logic [1:0] REG_TXDATA  = OFF_TXDATA[3:2];
  localparam logic [1:0] REG_STATUS  = OFF_STATUS[3:2];
  localparam logic [1:0] REG_BAUDDIV = OFF_BAUDDIV[3:2];

  localparam int STAT_BUSY   = 0;
  localparam int STAT_FULL   = 1;
  localparam int STAT_EMPTY  = 2;
  localparam int STAT_OVF    = 3;
  localparam int STAT_CNT_LO = 4;
  localparam int STAT_CNT_HI = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the store port and the serialiser; push/pop take effect on the clock edge, dout is the head.
// A push while full is dropped unless a pop happens in the same cycle.
module uart_tx_fifo
  import uart_mmio_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: zero-latency register reads, stores queued and sent as 8N1; start bit 1 cycle after the store edge.
// No backpressure to the CPU: a store to a full FIFO is dropped and flags sticky overflow.
module mmio_uart_tx
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        txd
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    state;
  logic [15:0]   baudDiv;
  logic [15:0]   divLatch;
  logic [15:0]   bitCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic          overflow;
  logic          txdReg;

  logic [1:0]    regIdx;
  logic          wrTxData;
  logic          wrStatus;
  logic          wrBaud;
  logic          bitDone;
  logic          busy;
  logic          pushDrop;
  logic [31:0]   statusWord;

  logic          fifoPush;
  logic          fifoPop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [7:0]    fifoDout;
  logic [CW-1:0] fifoCount;

  logic          unusedBits;
  assign unusedBits = ^{wdata[31:16], addr[1:0]};

  assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
  assign regIdx   = addr[3:2];
  assign wrTxData = sel && MemWrite && (regIdx == REG_TXDATA);
  assign wrStatus = sel && MemWrite && (regIdx == REG_STATUS);
  assign wrBaud   = sel && MemWrite && (regIdx == REG_BAUDDIV);

  assign bitDone  = (bitCnt == 16'd0);
  assign busy     = (state != ST_IDLE);

  // Pop from IDLE, or at the end of STOP so the next start bit follows with no gap.
  assign fifoPop  = !fifoEmpty && ((state == ST_IDLE) || ((state == ST_STOP) && bitDone));
  assign fifoPush = wrTxData && (!fifoFull || fifoPop);
  assign pushDrop = wrTxData && !fifoPush;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifoPush),
    .pop   (fifoPop),
    .din   (wdata[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_comb begin
    statusWord = '0;
    statusWord[STAT_BUSY]  = busy;
    statusWord[STAT_FULL]  = fifoFull;
    statusWord[STAT_EMPTY] = fifoEmpty;
    statusWord[STAT_OVF]   = overflow;
    statusWord[STAT_CNT_HI:STAT_CNT_LO] = 3'(fifoCount);
  end

  always_comb begin
    rdata = '0;
    if (sel && MemRead) begin
      case (regIdx)
        REG_STATUS:  rdata = statusWord;
        REG_BAUDDIV: rdata = {16'd0, baudDiv};
        default:     rdata = '0;
      endcase
    end
  end

  // Set beats clear when a dropped push and an overflow clear land together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baudDiv  <= DIV_RESET;
      overflow <= 1'b0;
    end else begin
      if (wrBaud) begin
        baudDiv <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      end
      if (pushDrop) begin
        overflow <= 1'b1;
      end else if (wrStatus && wdata[STAT_OVF]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      txdReg   <= 1'b1;
      bitCnt   <= 16'd0;
      divLatch <= DIV_RESET;
      bitIdx   <= 3'd0;
      shiftReg <= 8'd0;
    end else if (fifoPop) begin
      // Divisor is latched per frame so BAUDDIV writes mid-frame wait for the next one.
      state    <= ST_START;
      txdReg   <= 1'b0;
      shiftReg <= fifoDout;
      divLatch <= baudDiv;
      bitCnt   <= baudDiv;
    end else begin
      case (state)
        ST_START: begin
          if (bitDone) begin
            state    <= ST_DATA;
            txdReg   <= shiftReg[0];
            shiftReg <= {1'b0, shiftReg[7:1]};
            bitIdx   <= 3'd0;
            bitCnt   <= divLatch;
          end else begin
            bitCnt <= bitCnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (bitDone) begin
            bitCnt <= divLatch;
            if (bitIdx == 3'd7) begin
              state  <= ST_STOP;
              txdReg <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              txdReg   <= shiftReg[0];
              shiftReg <= {1'b0, shiftReg[7:1]};
            end
          end else begin
            bitCnt <= bitCnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (bitDone) begin
            state <= ST_IDLE;
          end else begin
            bitCnt <= bitCnt - 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign txd = txdReg;

endmodule
